// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline main control: opcodes, ALU op codes
// and the control bundles carried through the stage registers.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Full bundle produced by the decoder and held in ID/EX.
    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_dst;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    reg_write;
        logic    mem_to_reg;
        logic    valid;
    } ctrl_t;

    // Subsets that survive into later stages; EX-only bits are dropped.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
        logic mem_to_reg;
        logic valid;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic valid;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_BUBBLE     = ctrl_t'('0);
    localparam mem_ctrl_t MEM_CTRL_BUBBLE = mem_ctrl_t'('0);
    localparam wb_ctrl_t  WB_CTRL_BUBBLE  = wb_ctrl_t'('0);

    function automatic mem_ctrl_t to_mem_ctrl(input ctrl_t c);
        mem_ctrl_t m;
        m.mem_read   = c.mem_read;
        m.mem_write  = c.mem_write;
        m.branch     = c.branch;
        m.reg_write  = c.reg_write;
        m.mem_to_reg = c.mem_to_reg;
        m.valid      = c.valid;
        return m;
    endfunction

    function automatic wb_ctrl_t to_wb_ctrl(input mem_ctrl_t c);
        wb_ctrl_t w;
        w.reg_write  = c.reg_write;
        w.mem_to_reg = c.mem_to_reg;
        w.valid      = c.valid;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Pure combinational main decoder: opcode to control bundle, plus a flag
// for opcodes outside the supported set.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic       o_illegal
);

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        o_ctrl    = CTRL_BUBBLE;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
                o_ctrl.valid     = 1'b1;
            end
            OP_LW: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.valid      = 1'b1;
            end
            OP_SW: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.valid     = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALUOP_SUB;
                o_ctrl.valid  = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.valid     = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Main control for the 5-stage pipeline: decodes in ID and carries control
// through ID/EX, EX/MEM and MEM/WB, with bubbles on stall/flush.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush_id,
    input  logic             flush_ex,
    output logic [1:0]       ex_alu_op,
    output logic [5:0]       ex_funct,
    output logic             ex_alu_src,
    output logic             ex_reg_dst,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_branch,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt
);

    ctrl_t      w_dec_ctrl;
    logic       w_dec_illegal;
    logic       w_id_accept;

    ctrl_t      r_idex;
    logic [5:0] r_idex_funct;
    mem_ctrl_t  r_exmem;
    wb_ctrl_t   r_memwb;
    logic       r_illegal;
    logic [CNT_W-1:0] r_retired;

    ctrl_decoder u_decoder (
        .i_opcode  (id_opcode),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    // flush_id and stall both win over a real instruction in ID.
    assign w_id_accept = id_valid && !flush_id && !stall;

    // NOTE: state uses non-blocking assignments and a synchronous reset checked first in the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idex       <= CTRL_BUBBLE;
            r_idex_funct <= '0;
        end else if (w_id_accept && w_dec_ctrl.valid) begin
            r_idex       <= w_dec_ctrl;
            r_idex_funct <= id_funct;
        end else begin
            r_idex       <= CTRL_BUBBLE;
            r_idex_funct <= '0;
        end
    end

    // Later stages always advance; stall only affects what enters EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exmem <= MEM_CTRL_BUBBLE;
            r_memwb <= WB_CTRL_BUBBLE;
        end else begin
            r_exmem <= flush_ex ? MEM_CTRL_BUBBLE : to_mem_ctrl(r_idex);
            r_memwb <= to_wb_ctrl(r_exmem);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_id_accept && w_dec_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (r_memwb.valid) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign ex_alu_op     = r_idex.alu_op;
    assign ex_funct      = r_idex_funct;
    assign ex_alu_src    = r_idex.alu_src;
    assign ex_reg_dst    = r_idex.reg_dst;
    assign mem_read      = r_exmem.mem_read;
    assign mem_write     = r_exmem.mem_write;
    assign mem_branch    = r_exmem.branch;
    assign wb_reg_write  = r_memwb.reg_write;
    assign wb_mem_to_reg = r_memwb.mem_to_reg;
    assign illegal_op    = r_illegal;
    assign retired_cnt   = r_retired;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus random
// traffic against an instruction-level reference model.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic        id_valid;
    logic        stall;
    logic        flush_id;
    logic        flush_ex;

    logic [1:0]  ex_alu_op;
    logic [5:0]  ex_funct;
    logic        ex_alu_src, ex_reg_dst;
    logic        mem_read, mem_write, mem_branch;
    logic        wb_reg_write, wb_mem_to_reg;
    logic        illegal_op;
    logic [31:0] retired_cnt;

    // Narrow-counter instance on the same stimulus to reach the wrap point quickly.
    logic [1:0]  s_ex_alu_op;
    logic [5:0]  s_ex_funct;
    logic        s_ex_alu_src, s_ex_reg_dst;
    logic        s_mem_read, s_mem_write, s_mem_branch;
    logic        s_wb_reg_write, s_wb_mem_to_reg;
    logic        s_illegal_op;
    logic [2:0]  s_retired_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_valid(id_valid), .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex),
        .ex_alu_op(ex_alu_op), .ex_funct(ex_funct), .ex_alu_src(ex_alu_src),
        .ex_reg_dst(ex_reg_dst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_branch(mem_branch), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .illegal_op(illegal_op),
        .retired_cnt(retired_cnt)
    );

    pipe_ctrl_unit #(.CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_valid(id_valid), .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex),
        .ex_alu_op(s_ex_alu_op), .ex_funct(s_ex_funct), .ex_alu_src(s_ex_alu_src),
        .ex_reg_dst(s_ex_reg_dst), .mem_read(s_mem_read), .mem_write(s_mem_write),
        .mem_branch(s_mem_branch), .wb_reg_write(s_wb_reg_write),
        .wb_mem_to_reg(s_wb_mem_to_reg), .illegal_op(s_illegal_op),
        .retired_cnt(s_retired_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each pipeline slot names the instruction it holds.
    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] funct;
    } slot_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src, reg_dst, mem_read, mem_write, branch, reg_write, mem_to_reg;
    } bits_t;

    slot_t   m_ex, m_mem, m_wb;
    longint  m_retired;
    logic    m_ill;

    function automatic logic known(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08;
    endfunction

    // Control meaning of each instruction class, straight from the opcode table.
    function automatic bits_t bits_of(input slot_t s);
        bits_t b = '0;
        if (s.v) begin
            case (s.op)
                6'h00: begin b.reg_dst = 1; b.reg_write = 1; b.alu_op = 2'b10; end
                6'h23: begin b.alu_src = 1; b.mem_read = 1; b.mem_to_reg = 1; b.reg_write = 1; end
                6'h2B: begin b.alu_src = 1; b.mem_write = 1; end
                6'h04: begin b.branch = 1; b.alu_op = 2'b01; end
                6'h08: begin b.alu_src = 1; b.reg_write = 1; end
                default: b = '0;
            endcase
        end
        return b;
    endfunction

    task automatic model_edge();
        logic accept;
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_retired = 0; m_ill = 1'b0;
        end else begin
            if (m_wb.v) m_retired++;
            m_wb   = m_mem;
            m_mem  = flush_ex ? slot_t'('0) : m_ex;
            accept = id_valid && !flush_id && !stall;
            if (accept && !known(id_opcode)) m_ill = 1'b1;
            m_ex   = (accept && known(id_opcode)) ? slot_t'({1'b1, id_opcode, id_funct}) : slot_t'('0);
        end
    endtask

    task automatic compare_all();
        bits_t be = bits_of(m_ex);
        bits_t bm = bits_of(m_mem);
        bits_t bw = bits_of(m_wb);
        logic [5:0] ef = m_ex.v ? m_ex.funct : 6'd0;
        check("ex_bundle", {ex_alu_op, ex_funct, ex_alu_src, ex_reg_dst},
              {be.alu_op, ef, be.alu_src, be.reg_dst});
        check("mem_bundle", {mem_read, mem_write, mem_branch}, {bm.mem_read, bm.mem_write, bm.branch});
        check("wb_bundle", {wb_reg_write, wb_mem_to_reg}, {bw.reg_write, bw.mem_to_reg});
        check("illegal_op", illegal_op, m_ill);
        check("retired_cnt", retired_cnt, m_retired[31:0]);
        check("retired_cnt_w3", s_retired_cnt, m_retired[2:0]);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic v,
                         input logic st, input logic fid, input logic fex);
        id_opcode = op; id_funct = fn; id_valid = v; stall = st; flush_id = fid; flush_ex = fex;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    logic [31:0] base;

    initial begin
        rst_n = 1'b0; id_opcode = '0; id_funct = '0; id_valid = 0; stall = 0; flush_id = 0; flush_ex = 0;
        m_ex = '0; m_mem = '0; m_wb = '0; m_retired = 0; m_ill = 0;
        @(negedge clk);
        do_reset();
        check("reset_zero", {ex_alu_op, ex_funct, mem_read, wb_reg_write, illegal_op, retired_cnt}, 64'd0);

        // lw walks through EX, MEM, WB and is counted one cycle later.
        drive(6'h23, 6'h00, 1, 0, 0, 0);
        check("lw_ex", {ex_alu_src, ex_alu_op}, 3'b100);
        idle(1); check("lw_mem", mem_read, 1'b1);
        idle(1); check("lw_wb", {wb_mem_to_reg, wb_reg_write}, 2'b11);
        idle(1); check("lw_retired", retired_cnt, 32'd1);

        // R-type sub, then sw and beq back-to-back.
        drive(6'h00, 6'h22, 1, 0, 0, 0);
        check("rtype_ex", {ex_alu_op, ex_funct, ex_reg_dst}, {2'b10, 6'h22, 1'b1});
        drive(6'h2B, 6'h11, 1, 0, 0, 0);
        drive(6'h04, 6'h05, 1, 0, 0, 0);
        check("sw_mem", mem_write, 1'b1);
        idle(1); check("beq_mem", {mem_branch, mem_write}, 2'b10);
        idle(3);

        // Load-use stall: lw in EX, add held in ID for one cycle.
        do_reset();
        drive(6'h23, 6'h00, 1, 0, 0, 0);
        drive(6'h00, 6'h20, 1, 1, 0, 0);
        check("stall_ex_bubble", {ex_alu_op, ex_funct, ex_alu_src, ex_reg_dst}, 10'd0);
        check("stall_lw_mem", mem_read, 1'b1);
        drive(6'h00, 6'h20, 1, 0, 0, 0);
        drive(6'h08, 6'h00, 1, 0, 0, 0);
        drive(6'h2B, 6'h00, 1, 0, 0, 0);
        drive(6'h04, 6'h00, 1, 0, 0, 0);
        idle(5);
        check("stall_retired5", retired_cnt, 32'd5);

        // Simultaneous flush of ID (beq) and EX (addi).
        base = retired_cnt;
        drive(6'h08, 6'h00, 1, 0, 0, 0);
        drive(6'h04, 6'h00, 1, 0, 1, 1);
        check("flush_ex_zero", {ex_alu_op, ex_funct, ex_alu_src, ex_reg_dst}, 10'd0);
        check("flush_mem_zero", {mem_read, mem_write, mem_branch}, 3'd0);
        idle(4);
        check("flush_not_counted", retired_cnt, base);

        // Illegal opcode is sticky; a stalled one is ignored.
        drive(6'h3F, 6'h00, 1, 0, 0, 0);
        check("illegal_set", illegal_op, 1'b1);
        drive(6'h23, 6'h00, 1, 0, 0, 0);
        idle(3);
        check("illegal_sticky", illegal_op, 1'b1);
        do_reset();
        drive(6'h3F, 6'h00, 1, 1, 0, 0);
        idle(1);
        check("illegal_stalled", illegal_op, 1'b0);

        // Counter wrap on the narrow instance.
        do_reset();
        for (int i = 0; i < 7; i++) drive(6'h08, 6'h00, 1, 0, 0, 0);
        idle(4);
        check("wrap_allones", s_retired_cnt, 3'd7);
        drive(6'h00, 6'h20, 1, 0, 0, 0);
        idle(4);
        check("wrap_zero", s_retired_cnt, 3'd0);
        check("wrap_wide", retired_cnt, 32'd8);

        // Reset with three instructions in flight.
        drive(6'h23, 6'h00, 1, 0, 0, 0);
        drive(6'h00, 6'h24, 1, 0, 0, 0);
        drive(6'h2B, 6'h00, 1, 0, 0, 0);
        rst_n = 1'b0;
        drive(6'h08, 6'h00, 1, 0, 0, 0);
        check("rst_flight_zero", {ex_alu_op, ex_funct, ex_alu_src, ex_reg_dst, mem_read, mem_write,
              mem_branch, wb_reg_write, wb_mem_to_reg, illegal_op, retired_cnt}, 64'd0);
        drive(6'h00, 6'h20, 1, 0, 0, 0);
        check("rst_held_zero", {ex_alu_op, ex_funct, retired_cnt}, 40'd0);
        rst_n = 1'b1;
        idle(4);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] op;
            case ($urandom_range(0, 6))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                4: op = 6'h08;
                default: op = 6'($urandom);
            endcase
            rst_n = ($urandom_range(0, 79) != 0);
            drive(op, 6'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0));
        end
        rst_n = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
